// File: rtl/digital_clock_core_if.sv
// Control, set/alarm and display bundle between the clock core and its host.
interface digital_clock_core_if;
  logic        mode24;
  logic        run;
  logic        set_req;
  logic [7:0]  set_hr;
  logic [7:0]  set_min;
  logic [7:0]  set_sec;
  logic        set_pm;
  logic        set_ack;
  logic        set_err;
  logic [7:0]  alarm_hr;
  logic [7:0]  alarm_min;
  logic        alarm_pm;
  logic        alarm_arm;
  logic        alarm_ack;
  logic        alarm;
  logic        tick;
  logic        pm;
  logic [23:0] digi_clock;

  modport slave (
    input  mode24, run, set_req, set_hr, set_min, set_sec, set_pm,
    input  alarm_hr, alarm_min, alarm_pm, alarm_arm, alarm_ack,
    output set_ack, set_err, alarm, tick, pm, digi_clock
  );

  modport master (
    output mode24, run, set_req, set_hr, set_min, set_sec, set_pm,
    output alarm_hr, alarm_min, alarm_pm, alarm_arm, alarm_ack,
    input  set_ack, set_err, alarm, tick, pm, digi_clock
  );
endinterface

// File: rtl/digital_clock_core.sv
// BCD HH:MM:SS clock with 12/24 h mode, set handshake (1-cycle output latency, level req / pulse ack).
// Alarm compiled in with DIGITAL_CLOCK_ALARM_EN; otherwise alarm is tied low.
module digital_clock_core #(
  parameter int CLK_FREQ       = 100000,
  parameter int TICK_FREQ      = 1,
  parameter bit DEFAULT_MODE24 = 1'b0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  digital_clock_core_if.slave bus_io
);
  localparam int             DIV    = CLK_FREQ / TICK_FREQ;
  localparam int             PW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  TC     = PW'(DIV - 1);
  localparam logic [7:0]     RST_HR = DEFAULT_MODE24 ? 8'h00 : 8'h12;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic          pm_q, pm_d, mode_q, mode_d;
  logic          set_err_q, set_err_d, alarm_q, alarm_d;
  logic          tick, set_take, set_ok, load, advance;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_add12(input logic [7:0] v);
    logic [3:0] lo;
    lo = v[3:0] + 4'd2;
    if (lo > 4'd9) return {v[7:4] + 4'd2, lo - 4'd10};
    return {v[7:4] + 4'd1, lo};
  endfunction

  function automatic logic [7:0] bcd_sub12(input logic [7:0] v);
    if (v[3:0] < 4'd2) return {v[7:4] - 4'd2, v[3:0] + 4'd8};
    return {v[7:4] - 4'd1, v[3:0] - 4'd2};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

  assign tick = (presc_q == TC);

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pm_d      = pm_q;
    mode_d    = bus_io.mode24;
    set_err_d = set_err_q;
    alarm_d   = alarm_q;

    set_take = (state_q == IDLE) && bus_io.set_req;
    set_ok   = bcd_ok(bus_io.set_sec, 8'h00, 8'h59) && bcd_ok(bus_io.set_min, 8'h00, 8'h59) &&
               (bus_io.mode24 ? bcd_ok(bus_io.set_hr, 8'h00, 8'h23)
                              : bcd_ok(bus_io.set_hr, 8'h01, 8'h12));
    load     = set_take && set_ok;
    advance  = tick && bus_io.run && !set_take;

    // Advance in the stored format first so a same-cycle mode change converts the new time.
    if (advance) begin
      if (sec_d == 8'h59) begin
        sec_d = 8'h00;
        if (min_d == 8'h59) begin
          min_d = 8'h00;
          if (mode_q) begin
            hr_d = (hr_d == 8'h23) ? 8'h00 : bcd_inc(hr_d);
            pm_d = (hr_d >= 8'h12);
          end else if (hr_d == 8'h12) begin
            hr_d = 8'h01;
          end else if (hr_d == 8'h11) begin
            hr_d = 8'h12;
            pm_d = !pm_d;
          end else begin
            hr_d = bcd_inc(hr_d);
          end
        end else begin
          min_d = bcd_inc(min_d);
        end
      end else begin
        sec_d = bcd_inc(sec_d);
      end
    end

`ifdef DIGITAL_CLOCK_ALARM_EN
    if (!bus_io.alarm_arm || bus_io.alarm_ack) begin
      alarm_d = 1'b0;
    end else if (advance && hr_d == bus_io.alarm_hr && min_d == bus_io.alarm_min &&
                 sec_d == 8'h00 && (mode_q || bus_io.alarm_pm == pm_d)) begin
      alarm_d = 1'b1;
    end
`else
    alarm_d = 1'b0;
`endif

    if (bus_io.mode24 != mode_q && !load) begin
      if (bus_io.mode24) begin
        if (hr_d == 8'h12) hr_d = pm_d ? 8'h12 : 8'h00;
        else if (pm_d)     hr_d = bcd_add12(hr_d);
      end else begin
        pm_d = (hr_d >= 8'h12);
        if (hr_d == 8'h00)     hr_d = 8'h12;
        else if (hr_d > 8'h12) hr_d = bcd_sub12(hr_d);
      end
    end

    if (load) begin
      hr_d      = bus_io.set_hr;
      min_d     = bus_io.set_min;
      sec_d     = bus_io.set_sec;
      pm_d      = bus_io.mode24 ? (bus_io.set_hr >= 8'h12) : bus_io.set_pm;
      set_err_d = 1'b0;
      presc_d   = '0;
    end else if (set_take) begin
      set_err_d = 1'b1;
    end

    case (state_q)
      IDLE:     if (bus_io.set_req) state_d = ACK;
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!bus_io.set_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      hr_q      <= RST_HR;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      pm_q      <= 1'b0;
      mode_q    <= DEFAULT_MODE24;
      set_err_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pm_q      <= pm_d;
      mode_q    <= mode_d;
      set_err_q <= set_err_d;
      alarm_q   <= alarm_d;
    end
  end

`ifndef DIGITAL_CLOCK_ALARM_EN
  logic unused_alarm;
  assign unused_alarm = ^{bus_io.alarm_hr, bus_io.alarm_min, bus_io.alarm_pm,
                          bus_io.alarm_arm, bus_io.alarm_ack};
`endif

  assign bus_io.set_ack    = (state_q == ACK);
  assign bus_io.set_err    = set_err_q;
  assign bus_io.alarm      = alarm_q;
  assign bus_io.tick       = tick;
  assign bus_io.pm         = pm_q;
  assign bus_io.digi_clock = {hr_q, min_q, sec_q};
endmodule
